// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
// Resolves the branches and jumps handed over by the fetch/decode stage. An
// ID/EX register holds each control-flow instruction for one cycle. The
// execute stage then computes the redirect pair (PCSrcE, PCTargetE) and the
// link write. After a taken redirect, a small squash FSM turns the two
// wrong-path decode slots into bubbles.
// Optional build macro: BRANCH_STATS_EN adds the BranchCntE/TakenCntE
// statistics counters and their ports.
module branch_resolve_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            LinkWriteE,
    output logic [4:0]      RdE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic            SquashE
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     BranchCntE,
    output logic [31:0]     TakenCntE
`endif
);

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_BRANCH = 2'd1,
        CLS_JAL    = 2'd2,
        CLS_JALR   = 2'd3
    } ctrlClass_t;

    // Encoded as the squash count itself: 0 = normal flow, 1 = one more slot to kill
    typedef enum logic [1:0] {
        SQ_IDLE = 2'd0,
        SQ_ONE  = 2'd1
    } squashState_t;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    ctrlClass_t      classD;
    logic [XLEN-1:0] immD;

    logic            validE;
    ctrlClass_t      classE;
    logic [2:0]      funct3E;
    logic [XLEN-1:0] immE;
    logic [XLEN-1:0] pcE;
    logic [XLEN-1:0] pcPlus4E;
    logic [XLEN-1:0] rd1E;
    logic [XLEN-1:0] rd2E;
    logic [4:0]      rdE;
    logic            squashE;

    squashState_t    squashState;
    squashState_t    squashStateNext;
    logic            squashLoad;

    logic            taken;
    logic            redirect;
    logic [XLEN-1:0] jalrSum;
    logic [XLEN-1:0] target;

    // Decode the control-flow class and its sign-extended immediate; anything else is a bubble
    always_comb begin
        classD = CLS_NONE;
        immD   = '0;
        case (InstrD[6:0])
            OPC_BRANCH: begin
                immD = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                        InstrD[30:25], InstrD[11:8], 1'b0};
                // funct3 010/011 are not branch encodings
                if (InstrD[14:13] != 2'b01) begin
                    classD = CLS_BRANCH;
                end
            end
            OPC_JAL: begin
                immD   = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12],
                          InstrD[20], InstrD[30:21], 1'b0};
                classD = CLS_JAL;
            end
            OPC_JALR: begin
                immD = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
                if (InstrD[14:12] == 3'b000) begin
                    classD = CLS_JALR;
                end
            end
            default: begin
                classD = CLS_NONE;
            end
        endcase
    end

    // ID/EX register: loads decode every edge, or a cleared bubble while the squash FSM is killing slots
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validE   <= 1'b0;
            classE   <= CLS_NONE;
            funct3E  <= '0;
            immE     <= '0;
            pcE      <= '0;
            pcPlus4E <= '0;
            rd1E     <= '0;
            rd2E     <= '0;
            rdE      <= '0;
            squashE  <= 1'b0;
        end else if (squashLoad) begin
            validE   <= 1'b0;
            classE   <= CLS_NONE;
            funct3E  <= '0;
            immE     <= '0;
            pcE      <= '0;
            pcPlus4E <= '0;
            rd1E     <= '0;
            rd2E     <= '0;
            rdE      <= '0;
            squashE  <= 1'b1;
        end else begin
            validE   <= (classD != CLS_NONE);
            classE   <= classD;
            funct3E  <= InstrD[14:12];
            immE     <= immD;
            pcE      <= PCD;
            pcPlus4E <= PCPlus4D;
            rd1E     <= RD1D;
            rd2E     <= RD2D;
            rdE      <= InstrD[11:7];
            squashE  <= 1'b0;
        end
    end

    // Squash state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            squashState <= SQ_IDLE;
        end else begin
            squashState <= squashStateNext;
        end
    end

    // A redirect kills the slot in D now and the one fetched before the redirect lands
    always_comb begin
        squashStateNext = squashState;
        squashLoad      = 1'b0;
        case (squashState)
            SQ_IDLE: begin
                if (redirect) begin
                    squashLoad      = 1'b1;
                    squashStateNext = SQ_ONE;
                end
            end
            SQ_ONE: begin
                squashLoad      = 1'b1;
                squashStateNext = SQ_IDLE;
            end
            default: begin
                squashStateNext = SQ_IDLE;
            end
        endcase
    end

    // Execute: branch condition and target address, all arithmetic wrapping modulo 2^XLEN
    always_comb begin
        taken = 1'b0;
        case (funct3E)
            3'b000:  taken = (rd1E == rd2E);
            3'b001:  taken = (rd1E != rd2E);
            3'b100:  taken = ($signed(rd1E) <  $signed(rd2E));
            3'b101:  taken = ($signed(rd1E) >= $signed(rd2E));
            3'b110:  taken = (rd1E <  rd2E);
            3'b111:  taken = (rd1E >= rd2E);
            default: taken = 1'b0;
        endcase

        jalrSum = rd1E + immE;
        if (classE == CLS_JALR) begin
            target = {jalrSum[XLEN-1:1], 1'b0};
        end else begin
            target = pcE + immE;
        end
    end

    assign redirect   = validE & ((classE == CLS_JAL) | (classE == CLS_JALR) |
                                  ((classE == CLS_BRANCH) & taken));
    assign PCSrcE     = redirect;
    assign PCTargetE  = (!rst) ? RESET_PC : (validE ? target : pcPlus4E);
    assign LinkWriteE = validE & ((classE == CLS_JAL) | (classE == CLS_JALR)) &
                        (rdE != 5'd0);
    assign RdE        = rdE;
    assign PCPlus4E   = pcPlus4E;
    assign SquashE    = squashE;

`ifdef BRANCH_STATS_EN
    // Free-running statistics: resolved branches and taken redirects, both wrapping at 2^32
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            BranchCntE <= '0;
            TakenCntE  <= '0;
        end else begin
            if (validE && (classE == CLS_BRANCH)) begin
                BranchCntE <= BranchCntE + 32'd1;
            end
            if (redirect) begin
                TakenCntE <= TakenCntE + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration
`endif

endmodule
